// File: rtl/dmem_arb_if.sv
// Bus bundle between the MEM stage / EXT loader and the data memory arbiter.
interface dmem_arb_if #(
    parameter int unsigned D_WIDTH = 32
);
    // CPU (MEM stage) port
    logic               cpu_we;
    logic               cpu_re;
    logic [D_WIDTH-1:0] cpu_addr;
    logic [D_WIDTH-1:0] cpu_wdata;
    logic [D_WIDTH-1:0] cpu_rdata;
    logic               cpu_stall;

    // EXT (loader/debug) port
    logic               ext_req;
    logic               ext_we;
    logic [D_WIDTH-1:0] ext_addr;
    logic [D_WIDTH-1:0] ext_wdata;
    logic               ext_gnt;
    logic               ext_rvalid;
    logic [D_WIDTH-1:0] ext_rdata;

    // data_mem side
    logic               mem_we;
    logic               mem_re;
    logic [D_WIDTH-1:0] mem_w_addr;
    logic [D_WIDTH-1:0] mem_r_addr;
    logic [D_WIDTH-1:0] mem_w_data;
    logic [D_WIDTH-1:0] mem_r_data;

    // Arbiter view
    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_r_data,
        output cpu_rdata, cpu_stall,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_we, mem_re, mem_w_addr, mem_r_addr, mem_w_data
    );

    // Requester / memory view
    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_r_data,
        input  cpu_rdata, cpu_stall,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_we, mem_re, mem_w_addr, mem_r_addr, mem_w_data
    );
endinterface

// File: rtl/dmem_arb.sv
// Single-port data memory arbiter: CPU priority with starvation-bounded EXT bursts.
module dmem_arb #(
    parameter int unsigned D_WIDTH  = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned BURST    = 4
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST + 1);

    typedef enum logic [0:0] {
        CPU_PRI  = 1'b0,
        EXT_HOLD = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
    logic [BEAT_W-1:0]   beat_inc;
    logic                cpu_req;
    logic                cpu_gnt;
    logic                ext_gnt_c;
    logic                cpu_stall_c;
    logic                ext_rvalid;
    logic [D_WIDTH-1:0]  ext_rdata;

    assign cpu_req  = bus.cpu_we | bus.cpu_re;
    assign beat_inc = beat_cnt + BEAT_W'(1);

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CPU_PRI;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Grant decision, starvation counting and hold entry/exit
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        beat_nxt    = beat_cnt;
        cpu_gnt     = 1'b0;
        ext_gnt_c   = 1'b0;
        cpu_stall_c = 1'b0;
        case (state)
            CPU_PRI: begin
                cpu_gnt   = cpu_req;
                ext_gnt_c = bus.ext_req & ~cpu_req;
                if (ext_gnt_c || !bus.ext_req) begin
                    wait_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    // EXT has lost enough conflicts: force ownership next cycle
                    state_nxt = EXT_HOLD;
                    wait_nxt  = '0;
                    beat_nxt  = '0;
                end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            EXT_HOLD: begin
                ext_gnt_c   = bus.ext_req;
                cpu_stall_c = cpu_req;
                wait_nxt    = '0;
                if (!bus.ext_req || beat_inc == BEAT_W'(BURST)) begin
                    state_nxt = CPU_PRI;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat_inc;
                end
            end
            default: begin
                state_nxt = CPU_PRI;
                wait_nxt  = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    // Memory command mux: CPU owner, else EXT owner, else idle zeros
    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_w_addr = '0;
        bus.mem_r_addr = '0;
        bus.mem_w_data = '0;
        if (cpu_gnt) begin
            bus.mem_we     = bus.cpu_we;
            bus.mem_re     = bus.cpu_re;
            bus.mem_w_addr = bus.cpu_addr;
            bus.mem_r_addr = bus.cpu_addr;
            bus.mem_w_data = bus.cpu_wdata;
        end else if (ext_gnt_c) begin
            bus.mem_we     = bus.ext_we;
            bus.mem_re     = ~bus.ext_we;
            bus.mem_w_addr = bus.ext_addr;
            bus.mem_r_addr = bus.ext_addr;
            bus.mem_w_data = bus.ext_wdata;
        end
    end

    // EXT read return, one cycle after the read grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else if (ext_gnt_c && !bus.ext_we) begin
            ext_rvalid <= 1'b1;
            ext_rdata  <= bus.mem_r_data;
        end else begin
            ext_rvalid <= 1'b0;
        end
    end

    assign bus.cpu_rdata  = bus.mem_r_data;
    assign bus.cpu_stall  = cpu_stall_c;
    assign bus.ext_gnt    = ext_gnt_c;
    assign bus.ext_rvalid = ext_rvalid;
    assign bus.ext_rdata  = ext_rdata;

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- The CPU has priority by default. A starvation counter forces EXT grants after bounded waiting.
- During forced EXT ownership, `cpu_stall` tells the hazard logic to freeze the pipeline.
- Sits between the EX/MEM register outputs and the `data_mem` instance.

Parameters:
- D_WIDTH, 32, data and address width of both ports and the memory.
- MAX_WAIT, 4, consecutive conflict cycles EXT may lose before forced ownership; must be ≥1.
- BURST, 4, maximum consecutive EXT beats granted in forced ownership; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_we  in  1  CPU write request (from `exmem_mem_we`).
- cpu_re  in  1  CPU read request (from `exmem_mem_re`).
- cpu_addr  in  D_WIDTH  CPU address (from `exmem_alu_out`).
- cpu_wdata  in  D_WIDTH  CPU write data.
- cpu_rdata  out  D_WIDTH  CPU read data; combinational copy of `mem_r_data`.
- cpu_stall  out  1  CPU request present but not granted this cycle.
- ext_req  in  1  EXT request valid; held with its fields until granted.
- ext_we  in  1  EXT is a write (1) or a read (0).
- ext_addr  in  D_WIDTH  EXT address.
- ext_wdata  in  D_WIDTH  EXT write data.
- ext_gnt  out  1  EXT request accepted this cycle; combinational.
- ext_rvalid  out  1  registered pulse one cycle after an EXT read grant.
- ext_rdata  out  D_WIDTH  registered EXT read data; valid while `ext_rvalid` is high.
- mem_we, mem_re  out  1 each  to `data_mem` `we`/`re`.
- mem_w_addr, mem_r_addr  out  D_WIDTH  to `data_mem`; both carry the granted address.
- mem_w_data  out  D_WIDTH  to `data_mem` `w_data`.
- mem_r_data  in  D_WIDTH  from `data_mem`; valid in the same cycle as `mem_re`.

Behaviour:
- Memory command:
  - cpu_req = cpu_we | cpu_re.
  - Exactly one owner per cycle drives the `mem_*` fields: CPU if granted, else EXT if granted, else `mem_we` = `mem_re` = 0 and addresses/data = 0.
  - CPU grant drives `mem_we` = `cpu_we` and `mem_re` = `cpu_re`; both may be high together and pass through unchanged.
  - EXT grant drives `mem_we` = `ext_we` and `mem_re` = !`ext_we`.
- FSM states:
  - CPU_PRI (reset state):
    - CPU granted whenever cpu_req is high.
    - `ext_gnt` = `ext_req` & !cpu_req.
    - `cpu_stall` = 0.
  - EXT_HOLD:
    - `ext_gnt` = `ext_req`.
    - CPU is never granted; `cpu_stall` = cpu_req.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Increments on each CPU_PRI cycle with `ext_req` & cpu_req.
  - Clears on any EXT grant or when `ext_req` = 0.
  - Saturates at MAX_WAIT.
- Transition CPU_PRI→EXT_HOLD: when a conflict cycle occurs with wait_cnt == MAX_WAIT-1. The next cycle is EXT_HOLD; wait_cnt clears and beat_cnt loads 0.
- In EXT_HOLD, beat_cnt increments on each EXT grant. Return to CPU_PRI next cycle when either:
  - `ext_req` = 0 in the current cycle (hold is released after that cycle), or
  - the grant makes beat_cnt reach BURST.
- Forced ownership always yields at least one EXT grant if `ext_req` is still high on entry.
- EXT read return: on an EXT read grant, `ext_rdata` <= `mem_r_data` and `ext_rvalid` <= 1 at the next edge. Otherwise `ext_rvalid` <= 0 and `ext_rdata` holds its value.
- Reset values: state = CPU_PRI, wait_cnt = 0, beat_cnt = 0, `ext_rvalid` = 0, `ext_rdata` = 0. Combinational outputs follow from state with rst high.
- Reset mid-EXT_HOLD aborts the hold; no further EXT grants are issued until re-arbitration in CPU_PRI.
- Latency:
  - CPU: zero added cycles when not stalled.
  - EXT uncontended: grant in the same cycle as the request; read data 1 cycle later.
  - EXT worst-case wait: MAX_WAIT cycles, then a grant.

Test Plan:
- Reset, then idle: all mem_*/ext_gnt/ext_rvalid/cpu_stall are 0.
- CPU write addr 0x10 data 0xDEADBEEF with EXT idle → `mem_we` = 1, `mem_w_addr` = 0x10, `cpu_stall` = 0. Next CPU read of 0x10 → `cpu_rdata` = 0xDEADBEEF in the same cycle.
- CPU idle, EXT read 0x10 → `ext_gnt` = 1 in cycle N; `ext_rvalid` = 1 and `ext_rdata` = 0xDEADBEEF in cycle N+1, then `ext_rvalid` = 0.
- CPU requests every cycle, EXT writes 0x20 held, MAX_WAIT = 4 → no grant for 4 cycles; cycle 5 `ext_gnt` = 1 and `cpu_stall` = 1; 4 EXT beats (BURST = 4) with stall held; then CPU_PRI and `cpu_stall` = 0.
- In EXT_HOLD, drop `ext_req` after 2 beats → return to CPU_PRI the next cycle; wait_cnt = 0; the CPU is granted.
- Assert `rst` during the 2nd EXT_HOLD beat → next cycle: state CPU_PRI, `ext_rvalid` = 0, `cpu_stall` = 0; a held `ext_req` waits the full MAX_WAIT again.
